// File: rtl/pwls_reg_bus_arbiter_pkg.sv
// Shared types and constants for the PWL synth register-bus arbiter.
// SHIFT follows `INTERFACE_REGISTER_SHIFT from pwl_synth.vh when that header is in the build.
`ifndef INTERFACE_REGISTER_SHIFT
`define INTERFACE_REGISTER_SHIFT 3
`endif

package pwls_arb_pkg;

  localparam int unsigned SHIFT = `INTERFACE_REGISTER_SHIFT;

  localparam logic [1:0] STROBE_ON  = 2'b10;
  localparam logic [1:0] STROBE_OFF = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_SEQ  = 1'b1
  } owner_e;

endpackage

// File: rtl/pwls_reg_bus_arbiter_if.sv
// Requester, response and peripheral-side signals of the register-bus arbiter.
// slave = arbiter view; master = requesters + peripheral view.
interface pwls_reg_bus_arbiter_if
  import pwls_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned BITS_E    = 13
);

  logic                    host_valid;
  logic                    host_ready;
  logic                    host_write;
  logic [ADDR_BITS-1:0]    host_addr;
  logic [BITS_E-1:0]       host_wdata;
  logic                    host_rsp_valid;

  logic                    seq_valid;
  logic                    seq_ready;
  logic                    seq_write;
  logic [ADDR_BITS-1:0]    seq_addr;
  logic [BITS_E-1:0]       seq_wdata;
  logic                    seq_rsp_valid;

  logic [BITS_E-1:0]       rsp_rdata;
  logic                    rsp_err;

  logic [ADDR_BITS-1:0]    bus_addr;
  logic [BITS_E+SHIFT-1:0] bus_wdata;
  logic [1:0]              data_write_n;
  logic [1:0]              data_read_n;
  logic [BITS_E+SHIFT-1:0] bus_rdata;
  logic                    data_ready;
  logic                    busy;

  modport slave (
    input  host_valid, host_write, host_addr, host_wdata,
    input  seq_valid, seq_write, seq_addr, seq_wdata,
    input  bus_rdata, data_ready,
    output host_ready, host_rsp_valid, seq_ready, seq_rsp_valid,
    output rsp_rdata, rsp_err,
    output bus_addr, bus_wdata, data_write_n, data_read_n, busy
  );

  modport master (
    output host_valid, host_write, host_addr, host_wdata,
    output seq_valid, seq_write, seq_addr, seq_wdata,
    output bus_rdata, data_ready,
    input  host_ready, host_rsp_valid, seq_ready, seq_rsp_valid,
    input  rsp_rdata, rsp_err,
    input  bus_addr, bus_wdata, data_write_n, data_read_n, busy
  );

endinterface

// File: rtl/pwls_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one that did not win last.
module pwls_rr_pick2
  import pwls_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_i == OWN_HOST) ? 2'b10 : 2'b01;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/pwls_reg_bus_arbiter.sv
// Shares the synth register bus between host and sequencer, one access in flight.
// Optional read timeout: define PWLS_ARB_TIMEOUT_EN.
module pwls_reg_bus_arbiter
  import pwls_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 6,
  parameter int unsigned BITS_E         = 13,
  parameter int unsigned TIMEOUT_CYCLES = 15
)(
  input logic                   clk,
  input logic                   rst_n,
  pwls_reg_bus_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e              state_q;
  owner_e                  last_q;
  owner_e                  owner_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [BITS_E+SHIFT-1:0] wdata_q;
  logic [1:0]              wr_n_q;
  logic [1:0]              rd_n_q;
  logic [BITS_E-1:0]       rdata_q;
  logic                    host_rsp_q;
  logic                    seq_rsp_q;

  logic [1:0]              grant;
  logic                    accept;
  owner_e                  win;
  logic                    req_write;
  logic [ADDR_BITS-1:0]    req_addr;
  logic [BITS_E-1:0]       req_wdata;
  logic                    unused_rdata_lsbs;

  pwls_rr_pick2 u_pick (
    .valid_i ({bus.seq_valid, bus.host_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // ready is gated by rst_n so nothing can be accepted while reset is held
  assign bus.host_ready = rst_n && (state_q == IDLE) && grant[0];
  assign bus.seq_ready  = rst_n && (state_q == IDLE) && grant[1];
  assign accept         = bus.host_ready || bus.seq_ready;
  assign win            = grant[1] ? OWN_SEQ : OWN_HOST;

  always_comb begin
    req_write = bus.host_write;
    req_addr  = bus.host_addr;
    req_wdata = bus.host_wdata;
    if (win == OWN_SEQ) begin
      req_write = bus.seq_write;
      req_addr  = bus.seq_addr;
      req_wdata = bus.seq_wdata;
    end
  end

  assign unused_rdata_lsbs = ^bus.bus_rdata[SHIFT-1:0];

`ifdef PWLS_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= OWN_SEQ;
      owner_q    <= OWN_HOST;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_n_q     <= STROBE_OFF;
      rd_n_q     <= STROBE_OFF;
      rdata_q    <= '0;
      host_rsp_q <= 1'b0;
      seq_rsp_q  <= 1'b0;
`ifdef PWLS_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= {req_wdata, {SHIFT{1'b0}}};
            owner_q <= win;
            last_q  <= win;
            if (req_write) begin
              wr_n_q  <= STROBE_ON;
              state_q <= WRITE;
            end else begin
              rd_n_q  <= STROBE_ON;
              state_q <= READ;
`ifdef PWLS_ARB_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        WRITE: begin
          wr_n_q  <= STROBE_OFF;
          state_q <= IDLE;
        end
        READ: begin
          if (bus.data_ready) begin
            rdata_q    <= bus.bus_rdata[BITS_E+SHIFT-1:SHIFT];
            rd_n_q     <= STROBE_OFF;
            host_rsp_q <= (owner_q == OWN_HOST);
            seq_rsp_q  <= (owner_q == OWN_SEQ);
            state_q    <= RESP;
`ifdef PWLS_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // data_ready in the final cycle takes the branch above, so it beats the timeout
            rdata_q    <= '1;
            err_q      <= 1'b1;
            rd_n_q     <= STROBE_OFF;
            host_rsp_q <= (owner_q == OWN_HOST);
            seq_rsp_q  <= (owner_q == OWN_SEQ);
            state_q    <= RESP;
          end else begin
            to_cnt_q   <= to_cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          host_rsp_q <= 1'b0;
          seq_rsp_q  <= 1'b0;
          state_q    <= IDLE;
`ifdef PWLS_ARB_TIMEOUT_EN
          err_q      <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_addr       = addr_q;
  assign bus.bus_wdata      = wdata_q;
  assign bus.data_write_n   = wr_n_q;
  assign bus.data_read_n    = rd_n_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.host_rsp_valid = host_rsp_q;
  assign bus.seq_rsp_valid  = seq_rsp_q;
  assign bus.busy           = (state_q != IDLE);
`ifdef PWLS_ARB_TIMEOUT_EN
  assign bus.rsp_err        = err_q;
`else
  assign bus.rsp_err        = 1'b0;
`endif

endmodule
